apb_master_ctrl: RTL

- Sequences APB3 transfers (SETUP -> ACCESS) on behalf of two on-chip requesters.
- Arbitrates the requesters round-robin and drives the APB master pins (pclk pass-through, paddr, psel, penable, pwrite, pwdata).
- Returns prdata and completion status to the granted requester.
- Sits between processor-side load/store logic and the APB peripheral bus.

---
 rtl/apb_ctrl_pkg.sv | 19 +
 rtl/apb_rr_arb2.sv | 19 +
 rtl/apb_master_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and default widths for the APB master controller.
package apb_ctrl_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module apb_rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   // one-hot grant from the current valids and the previous winner
   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master sequencing transfers for two round-robin requesters.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES wait cycles.
module apb_master_ctrl
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              pclk,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   apb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              id_q, id_d;
   logic              last_grant_q, last_grant_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        grant_s;
   logic              timeout_s;

   apb_rr_arb2 u_arb (
      .valid_i      ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant_s)
   );

   assign req0_ready = (state_q == IDLE) & req0_valid & grant_s[0];
   assign req1_ready = (state_q == IDLE) & req1_valid & grant_s[1];

   // next-state, request capture and completion
   always_comb begin
      state_d      = state_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_rdata_d  = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               state_d      = SETUP;
               id_d         = req1_ready;
               last_grant_d = req1_ready;
               paddr_d      = req1_ready ? req1_addr  : req0_addr;
               pwrite_d     = req1_ready ? req1_write : req0_write;
               pwdata_d     = req1_ready ? req1_wdata : req0_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (pready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata;
            end else if (timeout_s) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_rdata_d = {DATA_W{1'b0}};
            end else begin
               state_d = ACCESS;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         paddr_q      <= {ADDR_W{1'b0}};
         pwrite_q     <= 1'b0;
         pwdata_q     <= {DATA_W{1'b0}};
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_rdata_q  <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             rsp_err_q, rsp_err_d;

   // the limit cycle itself still accepts pready as success
   assign timeout_s = (state_q == ACCESS) & ~pready & (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // ACCESS wait counter and error flag next-state
   always_comb begin
      wait_d    = wait_q;
      rsp_err_d = rsp_err_q;
      if (state_q == SETUP) begin
         wait_d = {CNT_W{1'b0}};
      end else if (state_q == ACCESS) begin
         wait_d = wait_q + CNT_W'(1);
      end else begin
         wait_d = wait_q;
      end
      if ((state_q == ACCESS) && pready) begin
         rsp_err_d = 1'b0;
      end else if (timeout_s) begin
         rsp_err_d = 1'b1;
      end else begin
         rsp_err_d = rsp_err_q;
      end
   end

   // timeout registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q    <= {CNT_W{1'b0}};
         rsp_err_q <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   logic [31:0] unused_timeout_s;
   assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
   assign timeout_s        = 1'b0;
   assign rsp_err          = 1'b0;
`endif

   assign pclk      = clk;
   assign psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable   = (state_q == ACCESS);
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
